line_raster: RTL and testbench
==============================

Name: line_raster

Overview:
Parametrised Bresenham line rasteriser for the GPU raster path. It accepts two endpoints, walks every octant, and streams one pixel coordinate per cycle to the framebuffer writer over a valid/ready interface. Compared with the earlier fixed 16-bit line drawer, it adds a configurable coordinate width, output backpressure, last-pixel tagging, an optional endpoint exclusion for polyline chaining, and a completion pulse.

Parameters:
COORD_W, 16, width of every coordinate (unsigned screen space)
INCLUDE_LAST, 1, 1 = emit the endpoint pixel; 0 = stop one pixel short of (x1,y1) for polyline joins

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a line; sampled only in IDLE
x0  in  COORD_W  start x, captured on accepted start
y0  in  COORD_W  start y, captured on accepted start
x1  in  COORD_W  end x, captured on accepted start
y1  in  COORD_W  end y, captured on accepted start
busy  out  1  high in SETUP, DRAW and DONE
pix_valid  out  1  pix_x/pix_y hold a valid pixel
pix_ready  in  1  downstream accepts the pixel this cycle
pix_x  out  COORD_W  current pixel x
pix_y  out  COORD_W  current pixel y
pix_last  out  1  qualifies the final pixel of the line
done  out  1  one-cycle pulse after the line completes

Behaviour:
- Clock is clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge), including mid-line: state goes to IDLE and the line in progress is discarded. busy, pix_valid, pix_last and done become 0. pix_x and pix_y become 0.
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE: on start=1, latch x0/y0/x1/y1 and move to SETUP. start is ignored in all other states.
- SETUP (1 cycle): compute the following.
  - dx = |x1-x0|, dy = -|y1-y0|, signed, COORD_W+2 bits.
  - sx = +1 if x0<x1, else -1. sy = +1 if y0<y1, else -1.
  - err = dx+dy, COORD_W+3 bits signed.
  - cnt = max(dx,|dy|) + INCLUDE_LAST, COORD_W+1 bits.
  - If cnt==0, go to DONE; otherwise load pix=(x0,y0) and go to DRAW.
- DRAW:
  - pix_valid=1 and pix_last=(cnt==1).
  - On pix_valid && pix_ready:
    - e2 = 2*err.
    - If e2>=dy: err+=dy, x+=sx.
    - If e2<=dx: err+=dx, y+=sy.
    - Both tests use the same e2; both updates accumulate into err.
    - cnt decrements by 1. When cnt was 1, go to DONE.
- Backpressure: while pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_last hold stable. pix_valid never drops without a handshake.
- DONE (1 cycle): done=1, pix_valid=0, busy=1, then go to IDLE.
- Latency:
  - start accepted at cycle 0 → SETUP at cycle 1 → first pix_valid at cycle 2.
  - With pix_ready held at 1, throughput is 1 pixel per cycle.
  - Last handshake at cycle k → done at k+1 → IDLE at k+2, when a new start is accepted.
- Pixels emitted = max(|x1-x0|,|y1-y0|) + INCLUDE_LAST.
- Coordinates never wrap: the walk terminates exactly at the endpoint. Lines touching 0 or 2^COORD_W-1 are legal.

Test Plan:
1. INCLUDE_LAST=1, pix_ready=1, start (0,0)→(5,2) at cycle 0 → pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on cycles 2–7; pix_last only on (5,2); done=1 at cycle 8; busy=0 at cycle 9.
2. Steep reverse line (3,7)→(1,0) → 8 pixels; y runs 7 down to 0 by one per pixel; x non-increasing from 3 to 1; last pixel is (1,0) with pix_last.
3. Case 1 with pix_ready driven by a pseudo-random pattern → identical pixel sequence; outputs stable on every stalled cycle; no pixel dropped or repeated.
4. Degenerate (4,4)→(4,4):
   - INCLUDE_LAST=1 → single pixel (4,4) with pix_last, then done.
   - INCLUDE_LAST=0 → no pix_valid; done=1 at cycle 2.
5. Start pulses in SETUP/DRAW/DONE → ignored.
6. Reset and extremes (COORD_W=16):
   - Reset on the cycle after the 3rd handshake → all outputs 0 on the next cycle and state IDLE; a new start then draws correctly.
   - (65535,0)→(0,3) → 65536 pixels; x decrements to 0 without wrap; last pixel is (0,3).

Source files
------------

// File: rtl/line_raster.sv
// Purpose: Bresenham line rasteriser that streams one pixel coordinate per cycle over all octants.
// Latency: start accepted at cycle 0, first pixel at cycle 2, done pulses the cycle after the last handshake.
// Backpressure: pix_x/pix_y/pix_last hold while pix_valid && !pix_ready; pix_valid never drops without a handshake.
//
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   start, x0, y0, x1, y1     : line request, endpoints captured when start is accepted in IDLE
//   busy                      : high in SETUP, DRAW and DONE
//   pix_valid/pix_ready       : pixel stream handshake
//   pix_x, pix_y, pix_last    : current pixel and final-pixel tag
//   done                      : one-cycle pulse after the line completes
module line_raster #(
  parameter int COORD_W      = 16,
  parameter int INCLUDE_LAST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               done
);

  localparam int DW = COORD_W + 2;  // dx / dy
  localparam int EW = COORD_W + 3;  // err
  localparam int CW = COORD_W + 1;  // pixel count

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t state, state_n;

  // captured endpoints
  logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;

  // walk state
  logic signed [DW-1:0] dx_r, dy_r;
  logic signed [EW-1:0] err_r;
  logic [CW-1:0]        cnt_r;
  logic                 sx_neg, sy_neg;

  // setup arithmetic
  logic [COORD_W-1:0]   adx, ady, amax;
  logic signed [DW-1:0] dx_s, dy_s;
  logic signed [EW-1:0] err_s;
  logic [CW-1:0]        cnt_s;

  // step arithmetic
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic signed [EW-1:0] dx_e, dy_e, err_n;
  logic                 step_x, step_y;
  logic [COORD_W-1:0]   x_inc, y_inc;
  logic                 last_pix;

  assign last_pix = (cnt_r == CW'(1));

  always_comb begin
    adx   = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
    ady   = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
    amax  = (adx >= ady) ? adx : ady;
    dx_s  = $signed({2'b00, adx});
    dy_s  = -$signed({2'b00, ady});
    err_s = $signed({dx_s[DW-1], dx_s}) + $signed({dy_s[DW-1], dy_s});
    cnt_s = {1'b0, amax} + CW'(INCLUDE_LAST);

    // Both decisions use the same doubled error; both corrections accumulate.
    e2     = $signed({err_r, 1'b0});
    dx_w   = $signed({{3{dx_r[DW-1]}}, dx_r});
    dy_w   = $signed({{3{dy_r[DW-1]}}, dy_r});
    dx_e   = $signed({dx_r[DW-1], dx_r});
    dy_e   = $signed({dy_r[DW-1], dy_r});
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    err_n  = err_r + (step_x ? dy_e : EW'(0)) + (step_y ? dx_e : EW'(0));

    // A step of -1 is all-ones; the add wraps modulo 2^COORD_W.
    x_inc = sx_neg ? {COORD_W{1'b1}} : COORD_W'(1);
    y_inc = sy_neg ? {COORD_W{1'b1}} : COORD_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state and outputs
  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = SETUP;
      end
      SETUP: begin
        busy    = 1'b1;
        state_n = (cnt_s == '0) ? DONE : DRAW;
      end
      DRAW: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        pix_last  = last_pix;
        if (pix_ready && last_pix) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_r   <= '0;
      y0_r   <= '0;
      x1_r   <= '0;
      y1_r   <= '0;
      dx_r   <= '0;
      dy_r   <= '0;
      err_r  <= '0;
      cnt_r  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      pix_x  <= '0;
      pix_y  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0_r <= x0;
            y0_r <= y0;
            x1_r <= x1;
            y1_r <= y1;
          end
        end
        SETUP: begin
          dx_r   <= dx_s;
          dy_r   <= dy_s;
          err_r  <= err_s;
          cnt_r  <= cnt_s;
          sx_neg <= !(x0_r < x1_r);
          sy_neg <= !(y0_r < y1_r);
          if (cnt_s != '0) begin
            pix_x <= x0_r;
            pix_y <= y0_r;
          end
        end
        DRAW: begin
          if (pix_ready) begin
            err_r <= err_n;
            cnt_r <= cnt_r - CW'(1);
            // Hold the coordinate on the final handshake so it never steps
            // past the endpoint (matters at the screen edges).
            if (!last_pix) begin
              if (step_x) pix_x <= pix_x + x_inc;
              if (step_y) pix_y <= pix_y + y_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster.sv
module tb_line_raster;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
    logic        ychk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        pix_ready = 1'b1;
  logic        pix_ready2 = 1'b1;

  logic        busy, pix_valid, pix_last, done;
  logic [15:0] pix_x, pix_y;
  logic        busy2, pix_valid2, pix_last2, done2;
  logic [15:0] pix_x2, pix_y2;

  always #5 clk = ~clk;

  line_raster #(.COORD_W(16), .INCLUDE_LAST(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
  );

  line_raster #(.COORD_W(16), .INCLUDE_LAST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy2), .pix_valid(pix_valid2), .pix_ready(pix_ready2),
    .pix_x(pix_x2), .pix_y(pix_y2), .pix_last(pix_last2), .done(done2)
  );

  exp_t q1[$];
  exp_t q2[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int first_rel = -1, done_rel = -1;
  int first2_rel = -1, done2_rel = -1;
  int hs1 = 0;
  bit rmode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  logic [15:0] prev_y = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        pix_ready = lfsr[0];
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  // monitor, full-length DUT
  bit          stalled = 1'b0;
  logic [15:0] hx, hy;
  logic        hl;
  exp_t        e1;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_x", pix_x, hx);
        chk("stall_y", pix_y, hy);
        chk("stall_last", pix_last, hl);
      end
      if (pix_valid && first_rel < 0) first_rel = cyc - c0;
      if (done && done_rel < 0) done_rel = cyc - c0;
      if (pix_valid && pix_ready) begin
        hs1++;
        stalled = 1'b0;
        if (q1.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("pix_x", pix_x, e1.x);
          if (e1.ychk) chk("pix_y", pix_y, e1.y);
          else chk("y_walk", (pix_y >= prev_y) && (pix_y - prev_y <= 1) && (pix_y <= 3), 1);
          chk("pix_last", pix_last, e1.last);
          prev_y = pix_y;
        end
      end else if (pix_valid) begin
        stalled = 1'b1;
        hx = pix_x;
        hy = pix_y;
        hl = pix_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // monitor, endpoint-excluding DUT
  exp_t e2;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid2 && first2_rel < 0) first2_rel = cyc - c0;
      if (done2 && done2_rel < 0) done2_rel = cyc - c0;
      if (pix_valid2 && pix_ready2) begin
        if (q2.size() == 0) begin
          chk("unexpected_pixel2", 1, 0);
        end else begin
          e2 = q2.pop_front();
          chk("pix_x2", pix_x2, e2.x);
          chk("pix_y2", pix_y2, e2.y);
          chk("pix_last2", pix_last2, e2.last);
        end
      end
    end
  end

  task automatic push1(input int x, input int y, input bit last);
    q1.push_back({x[15:0], y[15:0], last, 1'b1});
  endtask

  task automatic push2(input int x, input int y, input bit last);
    q2.push_back({x[15:0], y[15:0], last, 1'b1});
  endtask

  // Starts a line on the chosen DUT; returns in cycle 1 with start low.
  task automatic launch(input bit sel, input int ax0, input int ay0, input int ax1, input int ay1,
                        input bit hold);
    @(posedge clk);
    #1;
    x0 = ax0[15:0]; y0 = ay0[15:0]; x1 = ax1[15:0]; y1 = ay1[15:0];
    first_rel = -1; done_rel = -1; first2_rel = -1; done2_rel = -1;
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    @(negedge clk);
    c0 = cyc;
    @(posedge clk);
    #1;
    if (!hold) begin
      start  = 1'b0;
      start2 = 1'b0;
    end
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int n = 0;
    while (((sel ? done2_rel : done_rel) < 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(sel ? "done_timeout2" : "done_timeout", (sel ? done2_rel : done_rel) >= 0, 1);
  endtask

  task automatic push_line1;
    push1(0, 0, 0); push1(1, 0, 0); push1(2, 1, 0);
    push1(3, 1, 0); push1(4, 2, 0); push1(5, 2, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_last"}, pix_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_busy2", busy2, 0);
    chk("rst_valid2", pix_valid2, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // shallow line, full throughput, latency
    push_line1();
    launch(0, 0, 0, 5, 2, 0);
    wait_done(0, 50);
    chk("t1_first_cycle", first_rel, 2);
    chk("t1_done_cycle", done_rel, 8);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_drained", q1.size(), 0);

    // steep reverse line
    push1(3, 7, 0); push1(3, 6, 0); push1(2, 5, 0); push1(2, 4, 0);
    push1(2, 3, 0); push1(2, 2, 0); push1(1, 1, 0); push1(1, 0, 1);
    launch(0, 3, 7, 1, 0, 0);
    wait_done(0, 50);
    chk("t2_done_cycle", done_rel, 10);
    chk("t2_drained", q1.size(), 0);

    // random backpressure
    rmode = 1'b1;
    push_line1();
    launch(0, 0, 0, 5, 2, 0);
    wait_done(0, 300);
    rmode = 1'b0;
    chk("t3_drained", q1.size(), 0);

    // degenerate point, endpoint included
    push1(4, 4, 1);
    launch(0, 4, 4, 4, 4, 0);
    wait_done(0, 50);
    chk("t4_done_cycle", done_rel, 3);
    chk("t4_drained", q1.size(), 0);

    // degenerate point, endpoint excluded
    launch(1, 4, 4, 4, 4, 0);
    wait_done(1, 50);
    chk("t4b_done_cycle", done2_rel, 2);
    chk("t4b_no_valid", first2_rel, -1);

    // endpoint excluded, normal line
    push2(0, 0, 0); push2(1, 0, 0); push2(2, 1, 0); push2(3, 1, 0); push2(4, 2, 1);
    launch(1, 0, 0, 5, 2, 0);
    wait_done(1, 50);
    chk("t4c_done_cycle", done2_rel, 7);
    chk("t4c_drained", q2.size(), 0);

    // start held high through SETUP/DRAW/DONE with changed endpoints
    push_line1();
    launch(0, 0, 0, 5, 2, 1);
    x0 = 16'd9; y0 = 16'd9; x1 = 16'd20; y1 = 16'd30;
    wait_done(0, 50);
    #1 start = 1'b0;
    chk("t5_done_cycle", done_rel, 8);
    @(negedge clk);
    chk("t5_busy_idle", busy, 0);
    @(negedge clk);
    chk("t5_busy_still_idle", busy, 0);
    chk("t5_drained", q1.size(), 0);

    // reset mid-line, after the third handshake
    begin
      int base;
      int n;
      base = hs1;
      n = 0;
      push1(0, 0, 0); push1(1, 0, 0); push1(2, 1, 0);
      launch(0, 0, 0, 5, 2, 0);
      while (hs1 < base + 3 && n < 50) begin
        @(posedge clk);
        n++;
      end
      chk("t6_three_handshakes", hs1 - base, 3);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("t6_rst");
      chk("t6_drained", q1.size(), 0);
    end

    // fresh line after reset
    push_line1();
    launch(0, 0, 0, 5, 2, 0);
    wait_done(0, 50);
    chk("t6_first_cycle", first_rel, 2);
    chk("t6_done_cycle", done_rel, 8);
    chk("t6_redraw_drained", q1.size(), 0);

    // full-width line at the screen edges
    for (int i = 0; i < 65536; i++) begin
      exp_t e;
      e.x    = 16'(65535 - i);
      e.y    = (i == 65535) ? 16'd3 : 16'd0;
      e.last = (i == 65535);
      e.ychk = (i == 0) || (i == 65535);
      q1.push_back(e);
    end
    prev_y = '0;
    launch(0, 65535, 0, 0, 3, 0);
    wait_done(0, 70000);
    chk("t7_done_cycle", done_rel, 65538);
    chk("t7_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
